// File: rtl/output_handler_pkg.sv
// Shared constants and FSM encoding for the host link character framing
// (used by both the command receiver and the result transmitter).
package output_handler_pkg;

    localparam logic [7:0] CHAR_L    = 8'h4C;
    localparam logic [7:0] CHAR_0    = 8'h30;
    localparam logic [7:0] CHAR_LF   = 8'h0A;
    localparam int         MAX_CHARS = 32;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SEND_LEAD = 3'd1,
        ST_SEND_CMD  = 3'd2,
        ST_SEND_DATA = 3'd3,
        ST_SEND_TERM = 3'd4,
        ST_DONE      = 3'd5
    } state_t;

    // Requested data length limited to the number of byte lanes available.
    function automatic logic [5:0] clamp_count(input logic [5:0] cnt, input logic [5:0] max_cnt);
        return (cnt > max_cnt) ? max_cnt : cnt;
    endfunction

endpackage

// File: rtl/output_handler.sv
// Serialises a result buffer as an ASCII frame 'L', cmd, n data chars, optional LF
// toward the UART transmitter over a valid/ready byte interface.
module output_handler
    import output_handler_pkg::*;
#(
    parameter int MAX_CHARS = 32,
    parameter bit TERM_EN   = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [3:0]             command,
    input  logic [5:0]             char_count,
    input  logic [8*MAX_CHARS-1:0] data,
    output logic                   busy,
    output logic                   done,
    output logic [7:0]             tx_byte,
    output logic                   tx_valid,
    input  logic                   tx_ready
);

    localparam int DATA_W = 8 * MAX_CHARS;

    state_t              state_r;
    logic [3:0]          cmd_r;
    logic [5:0]          cnt_r;
    logic [DATA_W-1:0]   shreg_r;

    logic [5:0]          n_s;
    logic [31:0]         shamt_s;
    logic [DATA_W-1:0]   load_s;
    logic [DATA_W-1:0]   shift_s;
    logic [7:0]          first_char_s;
    logic [7:0]          next_char_s;
    logic                xfer_s;
    state_t              end_state_s;
    logic [7:0]          end_byte_s;
    logic                end_valid_s;
    logic                end_done_s;

    // Next-value helpers: load alignment, lane shift, char encoding and end-of-body target.
    always_comb begin
        n_s          = clamp_count(char_count, 6'(MAX_CHARS));
        // Left-align the lowest n lanes so the first char to send sits in the top lane.
        shamt_s      = (32'(MAX_CHARS) - {26'd0, n_s}) << 32'd3;
        load_s       = data << shamt_s;
        shift_s      = shreg_r << 32'd8;
        first_char_s = CHAR_0 + {4'h0, shreg_r[DATA_W-5 -: 4]};
        next_char_s  = CHAR_0 + {4'h0, shift_s[DATA_W-5 -: 4]};
        xfer_s       = tx_valid & tx_ready;
        if (TERM_EN) begin
            end_state_s = ST_SEND_TERM;
            end_byte_s  = CHAR_LF;
            end_valid_s = 1'b1;
            end_done_s  = 1'b0;
        end else begin
            end_state_s = ST_DONE;
            end_byte_s  = 8'h00;
            end_valid_s = 1'b0;
            end_done_s  = 1'b1;
        end
    end

    // Frame FSM with registered handshake outputs; tx_byte only changes on transfer or state entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            cmd_r    <= 4'h0;
            cnt_r    <= 6'd0;
            shreg_r  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            tx_byte  <= 8'h00;
            tx_valid <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        cmd_r    <= command;
                        cnt_r    <= n_s;
                        shreg_r  <= load_s;
                        busy     <= 1'b1;
                        tx_valid <= 1'b1;
                        tx_byte  <= CHAR_L;
                        state_r  <= ST_SEND_LEAD;
                    end
                end
                ST_SEND_LEAD: begin
                    if (xfer_s) begin
                        tx_byte <= CHAR_0 + {4'h0, cmd_r};
                        state_r <= ST_SEND_CMD;
                    end
                end
                ST_SEND_CMD: begin
                    if (xfer_s) begin
                        if (cnt_r == 6'd0) begin
                            tx_byte  <= end_byte_s;
                            tx_valid <= end_valid_s;
                            done     <= end_done_s;
                            state_r  <= end_state_s;
                        end else begin
                            tx_byte <= first_char_s;
                            state_r <= ST_SEND_DATA;
                        end
                    end
                end
                ST_SEND_DATA: begin
                    if (xfer_s) begin
                        shreg_r <= shift_s;
                        cnt_r   <= cnt_r - 6'd1;
                        if (cnt_r == 6'd1) begin
                            tx_byte  <= end_byte_s;
                            tx_valid <= end_valid_s;
                            done     <= end_done_s;
                            state_r  <= end_state_s;
                        end else begin
                            tx_byte <= next_char_s;
                        end
                    end
                end
                ST_SEND_TERM: begin
                    if (xfer_s) begin
                        tx_byte  <= 8'h00;
                        tx_valid <= 1'b0;
                        done     <= 1'b1;
                        state_r  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    busy     <= 1'b0;
                    done     <= 1'b0;
                    tx_valid <= 1'b0;
                    tx_byte  <= 8'h00;
                    state_r  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_output_handler.sv
// Randomised scoreboard bench: instance 0 appends LF, instance 1 has no terminator.
module tb_output_handler;

    logic         clk = 1'b0;
    logic         rst;
    logic         start      [2];
    logic [3:0]   command    [2];
    logic [5:0]   char_count [2];
    logic [255:0] data       [2];
    logic         busy       [2];
    logic         done       [2];
    logic [7:0]   tx_byte    [2];
    logic         tx_valid   [2];
    logic         tx_ready   [2];

    logic [7:0] exp_q [2][$];
    int n_checks = 0;
    int n_fail   = 0;
    int xfer_cnt [2] = '{0, 0};
    int done_cnt [2] = '{0, 0};
    int frames   [2] = '{0, 0};

    always #5 clk = ~clk;

    output_handler #(.MAX_CHARS(32), .TERM_EN(1'b1)) dut_t (
        .clk(clk), .rst(rst), .start(start[0]), .command(command[0]),
        .char_count(char_count[0]), .data(data[0]), .busy(busy[0]), .done(done[0]),
        .tx_byte(tx_byte[0]), .tx_valid(tx_valid[0]), .tx_ready(tx_ready[0])
    );

    output_handler #(.MAX_CHARS(32), .TERM_EN(1'b0)) dut_n (
        .clk(clk), .rst(rst), .start(start[1]), .command(command[1]),
        .char_count(char_count[1]), .data(data[1]), .busy(busy[1]), .done(done[1]),
        .tx_byte(tx_byte[1]), .tx_valid(tx_valid[1]), .tx_ready(tx_ready[1])
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference frame straight from the framing rules.
    task automatic push_frame(input int d, input logic [3:0] cmd, input logic [5:0] cc,
                              input logic [255:0] dat);
        int n;
        logic [7:0] lane;
        n = (cc > 6'd32) ? 32 : int'(cc);
        exp_q[d].push_back(8'h4C);
        exp_q[d].push_back(8'h30 + {4'h0, cmd});
        for (int i = n - 1; i >= 0; i--) begin
            lane = dat[8*i +: 8];
            exp_q[d].push_back(8'h30 + {4'h0, lane[3:0]});
        end
        if (d == 0) exp_q[d].push_back(8'h0A);
    endtask

    function automatic logic [255:0] rand_data();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_mon
        logic       prev_stall = 1'b0;
        logic       prev_done  = 1'b0;
        logic [7:0] prev_byte  = 8'h00;
        // Monitor: scoreboard pop on each handshake, hold-while-stalled and done-pulse checks.
        always @(negedge clk) begin
            if (!rst && prev_stall) begin
                chk("hold_valid", 32'(tx_valid[g]), 32'd1);
                chk("hold_byte", 32'(tx_byte[g]), 32'(prev_byte));
            end
            if (!rst && prev_done) begin
                chk("done_one_cycle", 32'(done[g]), 32'd0);
                chk("busy_after_done", 32'(busy[g]), 32'd0);
            end
            prev_stall = tx_valid[g] && !tx_ready[g] && !rst;
            prev_done  = done[g] && !rst;
            prev_byte  = tx_byte[g];
            if (!rst && tx_valid[g] && tx_ready[g]) begin
                if (exp_q[g].size() == 0) chk("spurious_char", 32'(tx_byte[g]), 32'h100);
                else chk("tx_byte", 32'(tx_byte[g]), 32'(exp_q[g].pop_front()));
                xfer_cnt[g]++;
            end
            if (!rst && done[g]) begin
                chk("done_frame_complete", 32'(exp_q[g].size()), 32'd0);
                chk("busy_in_done", 32'(busy[g]), 32'd1);
                done_cnt[g]++;
            end
        end
    end

    task automatic drive_start(input int d, input logic [3:0] cmd, input logic [5:0] cc,
                               input logic [255:0] dat);
        push_frame(d, cmd, cc, dat);
        start[d]      = 1'b1;
        command[d]    = cmd;
        char_count[d] = cc;
        data[d]       = dat;
    endtask

    // One frame; rnd adds 30%-duty tx_ready and ignored start pulses while busy.
    task automatic run_frame(input int d, input logic [3:0] cmd, input logic [5:0] cc,
                             input logic [255:0] dat, input bit rnd, input int exp_busy);
        int  busy_cycles = 0;
        bit  seen = 1'b0;
        drive_start(d, cmd, cc, dat);
        tx_ready[d] = rnd ? ($urandom_range(0, 9) < 3) : 1'b1;
        @(posedge clk); #1;
        start[d] = 1'b0;
        chk("first_valid", 32'(tx_valid[d]), 32'd1);
        chk("first_busy", 32'(busy[d]), 32'd1);
        for (int b = 0; b < 3000 && !seen; b++) begin
            if (busy[d]) busy_cycles++;
            if (done[d]) begin
                seen = 1'b1;
            end else begin
                tx_ready[d] = rnd ? ($urandom_range(0, 9) < 3) : 1'b1;
                start[d]    = rnd ? ($urandom_range(0, 3) == 0) : 1'b0;
                command[d]  = 4'($urandom);
                data[d]     = rand_data();
                @(posedge clk); #1;
            end
        end
        start[d] = 1'b0;
        if (!seen) begin
            chk("frame_timeout", 32'd0, 32'd1);
            exp_q[d].delete();
        end else begin
            frames[d]++;
        end
        if (exp_busy >= 0) chk("busy_cycles", 32'(busy_cycles), 32'(exp_busy));
        @(posedge clk); #1;
        chk("idle_busy", 32'(busy[d]), 32'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] dat;
        int base;
        bit hit;
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            start[d] = 1'b0; command[d] = 4'h0; char_count[d] = 6'd0;
            data[d] = '0; tx_ready[d] = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("rst_busy", 32'(busy[d]), 32'd0);
            chk("rst_done", 32'(done[d]), 32'd0);
            chk("rst_valid", 32'(tx_valid[d]), 32'd0);
            chk("rst_byte", 32'(tx_byte[d]), 32'd0);
        end
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed: 4C,33,31,3A,3F,30,0A with busy high for 8 cycles.
        dat = '0;
        dat[31:0] = 32'h010A_0F00;
        run_frame(0, 4'd3, 6'd4, dat, 1'b0, 8);
        run_frame(0, 4'd15, 6'd0, rand_data(), 1'b0, 4);
        for (int k = 0; k < 32; k++) dat[8*k +: 8] = 8'(k);
        run_frame(0, 4'd7, 6'd40, dat, 1'b0, 36);
        run_frame(0, 4'd9, 6'd32, rand_data(), 1'b1, -1);
        for (int i = 0; i < 6; i++)
            run_frame(0, 4'($urandom), 6'($urandom_range(0, 40)), rand_data(), 1'b1, -1);

        // Abort after the second data char, then a fresh frame.
        base = xfer_cnt[0];
        drive_start(0, 4'd5, 6'd10, rand_data());
        tx_ready[0] = 1'b1;
        hit = 1'b0;
        for (int b = 0; b < 100 && !hit; b++) begin
            @(posedge clk); #1;
            start[0] = 1'b0;
            if (xfer_cnt[0] >= base + 4) hit = 1'b1;
        end
        chk("abort_reach", 32'(hit), 32'd1);
        rst = 1'b1;
        tx_ready[0] = 1'b0;
        @(posedge clk); #1;
        chk("abort_valid", 32'(tx_valid[0]), 32'd0);
        chk("abort_busy", 32'(busy[0]), 32'd0);
        chk("abort_done", 32'(done[0]), 32'd0);
        rst = 1'b0;
        exp_q[0].delete();
        @(posedge clk); #1;
        run_frame(0, 4'd2, 6'd3, rand_data(), 1'b1, -1);

        // No-terminator instance: 4C,31,35 (upper nibble of lane0 ignored).
        dat = '0;
        dat[7:0] = 8'h25;
        run_frame(1, 4'd1, 6'd1, dat, 1'b0, 4);
        run_frame(1, 4'd6, 6'd0, rand_data(), 1'b0, 3);
        for (int i = 0; i < 3; i++)
            run_frame(1, 4'($urandom), 6'($urandom_range(0, 40)), rand_data(), 1'b1, -1);

        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("done_count", 32'(done_cnt[d]), 32'(frames[d]));
            chk("queue_drained", 32'(exp_q[d].size()), 32'd0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
